// File: rtl/alu_muldiv_pkg.sv
// Shared types and op-decode helpers for the iterative RV32M multiply/divide unit.
package alu_muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_rem(muldiv_op_t op);
    return op[2] & op[1];
  endfunction

  function automatic logic is_signed_a(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/alu_muldiv_signfix.sv
// Combinational magnitude / conditional-negation helper shared by the mul and div paths.
module muldiv_signfix
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               a_neg,
  input  logic               b_neg,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   quo,
  input  logic [WIDTH-1:0]   rem,
  input  logic               neg_qp,
  input  logic               neg_r,
  output logic [WIDTH-1:0]   abs_a,
  output logic [WIDTH-1:0]   abs_b,
  output logic [2*WIDTH-1:0] prod_fix,
  output logic [WIDTH-1:0]   quo_fix,
  output logic [WIDTH-1:0]   rem_fix
);

  assign abs_a    = a_neg  ? -a    : a;
  assign abs_b    = b_neg  ? -b    : b;
  assign prod_fix = neg_qp ? -prod : prod;
  assign quo_fix  = neg_qp ? -quo  : quo;
  assign rem_fix  = neg_r  ? -rem  : rem;

endmodule

// File: rtl/alu_muldiv.sv
// Iterative radix-2 multiply/divide unit (RV32M); one step per clock, start/busy/valid handshake.
// Build option: MULDIV_DIV_EN enables the divider; otherwise DIV*/REM* report illegal.
module alu_muldiv
  import alu_muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             CLOCK,
  input  logic             RESET,
  input  logic             start,
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic             busy,
  output logic             valid,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             div0,
  output logic             illegal
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t             state, state_nxt;
  muldiv_op_t         op_in, op_q;
  logic [CW-1:0]      cnt;
  logic [2*WIDTH-1:0] acc, acc_step;
  logic [WIDTH-1:0]   mag_b;
  logic               neg_qp, neg_r;
  logic               a_neg_in, b_neg_in;
  logic [WIDTH-1:0]   abs_a, abs_b, quo_fix, rem_fix;
  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH:0]     mul_sum;
  logic               special, spec_div0, spec_ill;
  logic [WIDTH-1:0]   spec_res, fix_res;
  logic               last_step;

  assign op_in     = muldiv_op_t'(op);
  assign a_neg_in  = is_signed_a(op_in) & A[WIDTH-1];
  assign b_neg_in  = is_signed_b(op_in) & B[WIDTH-1];
  assign last_step = (cnt == CW'(WIDTH - 1));

  // Sign fix is applied to the post-step accumulator so the last step and the fix share one edge.
  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .a(A), .b(B), .a_neg(a_neg_in), .b_neg(b_neg_in),
    .prod(acc_step), .quo(acc_step[WIDTH-1:0]), .rem(acc_step[2*WIDTH-1:WIDTH]),
    .neg_qp(neg_qp), .neg_r(neg_r),
    .abs_a(abs_a), .abs_b(abs_b), .prod_fix(prod_fix), .quo_fix(quo_fix), .rem_fix(rem_fix)
  );

`ifdef MULDIV_DIV_EN
  localparam logic [WIDTH-1:0] MIN_INT = {1'b1, {(WIDTH-1){1'b0}}};
  logic [WIDTH:0] div_sh, div_diff;
`endif

  always_comb begin
    mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, mag_b} : '0);
    acc_step = {mul_sum, acc[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    div_sh   = acc[2*WIDTH-1:WIDTH-1];
    div_diff = div_sh - {1'b0, mag_b};
    if (is_div(op_q)) begin
      if (!div_diff[WIDTH]) acc_step = {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
      else                  acc_step = {acc[2*WIDTH-2:0], 1'b0};
    end
`endif
  end

  always_comb begin
    special   = 1'b0;
    spec_res  = '0;
    spec_div0 = 1'b0;
    spec_ill  = 1'b0;
`ifdef MULDIV_DIV_EN
    if (is_div(op_in)) begin
      if (B == '0) begin
        special   = 1'b1;
        spec_div0 = 1'b1;
        spec_res  = is_rem(op_in) ? A : '1;
      end else if (is_signed_b(op_in) && (A == MIN_INT) && (B == '1)) begin
        special  = 1'b1;
        spec_res = is_rem(op_in) ? '0 : MIN_INT;
      end
    end
`else
    if (is_div(op_in)) begin
      special  = 1'b1;
      spec_ill = 1'b1;
    end
`endif
  end

  always_comb begin
    fix_res = rem_fix;
    case (op_q)
      OP_MUL:                        fix_res = prod_fix[WIDTH-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod_fix[2*WIDTH-1:WIDTH];
      OP_DIV, OP_DIVU:               fix_res = quo_fix;
      default:                       fix_res = rem_fix;
    endcase
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = special ? DONE : CALC;
      CALC:    if (last_step) state_nxt = DONE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy  = (state != IDLE);
    valid = (state == DONE);
  end

  always_ff @(posedge CLOCK) begin
    if (RESET) begin
      op_q    <= OP_MUL;
      cnt     <= '0;
      acc     <= '0;
      mag_b   <= '0;
      neg_qp  <= 1'b0;
      neg_r   <= 1'b0;
      result  <= '0;
      zero    <= 1'b0;
      div0    <= 1'b0;
      illegal <= 1'b0;
    end else begin
      case (state)
        IDLE: if (start) begin
          op_q   <= op_in;
          cnt    <= '0;
          acc    <= {{WIDTH{1'b0}}, abs_a};
          mag_b  <= abs_b;
          neg_qp <= a_neg_in ^ b_neg_in;
          neg_r  <= a_neg_in;
          if (special) begin
            result  <= spec_res;
            zero    <= (spec_res == '0);
            div0    <= spec_div0;
            illegal <= spec_ill;
          end
        end
        CALC: begin
          acc <= acc_step;
          cnt <= cnt + CW'(1);
          if (last_step) begin
            result  <= fix_res;
            zero    <= (fix_res == '0);
            div0    <= 1'b0;
            illegal <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
